y86_seq_sequencer: RTL and testbench

Multi-cycle control FSM for the Y86-64 SEQ processor. Sequences one instruction at a time through fetch, decode, execute, memory, write-back and PC-update by issuing one-cycle stage-enable strobes. The PC-update register is written only on the `pc_en` strobe. The block owns the processor status code, and stops the machine on halt, invalid instruction or memory fault.

---
 rtl/y86_pkg.sv | 42 ++++
 rtl/y86_seq_sequencer_if.sv | 41 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/y86_seq_sequencer.sv | 146 ++++++++++++++
 tb/tb_y86_seq_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ control sequencer:
// status codes, instruction codes and FSM states.
package y86_pkg;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPD,
      S_HALT
   } state_t;

   // Instructions that touch data memory and so visit MEMORY.
   function automatic logic is_mem_icode(input logic [3:0] ic);
      return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL,
                        I_RET, I_PUSHQ, I_POPQ};
   endfunction

endpackage

// File: rtl/y86_seq_sequencer_if.sv
// Control/status bundle between the SEQ datapath and its sequencer.
interface y86_seq_sequencer_if;

   logic        start;
   logic        step_mode;
   logic [3:0]  icode;
   logic        instr_valid;
   logic        imem_error;
   logic        mem_ready;
   logic        dmem_error;

   logic        f_en;
   logic        d_en;
   logic        e_en;
   logic        m_en;
   logic        w_en;
   logic        pc_en;
   logic        mem_req;
   logic [2:0]  stat;
   logic        busy;
   logic        halted;
   logic [63:0] instr_count;
   logic [63:0] cycle_count;

   modport master (
      output start, step_mode, icode, instr_valid,
      output imem_error, mem_ready, dmem_error,
      input  f_en, d_en, e_en, m_en, w_en, pc_en,
      input  mem_req, stat, busy, halted,
      input  instr_count, cycle_count
   );

   modport slave (
      input  start, step_mode, icode, instr_valid,
      input  imem_error, mem_ready, dmem_error,
      output f_en, d_en, e_en, m_en, w_en, pc_en,
      output mem_req, stat, busy, halted,
      output instr_count, cycle_count
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for the MEMORY state of the SEQ sequencer.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // Fires in the waiting cycle whose increment reaches the limit.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/y86_seq_sequencer.sv
// Multi-cycle control FSM for the Y86-64 SEQ processor: stage strobes,
// status ownership and instruction/cycle accounting.
module y86_seq_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input logic clk,
   input logic reset,
   y86_seq_sequencer_if.slave bus
);

   import y86_pkg::*;

   state_t      state;
   state_t      nxt;
   stat_t       stat_q;
   stat_t       stat_nxt;
   logic [3:0]  icode_q;

   logic        f_q;
   logic        d_q;
   logic        e_q;
   logic        w_q;
   logic        pc_q;
   logic        mem_req_q;
   logic        busy_q;
   logic        halted_q;
   logic [63:0] icnt;
   logic [63:0] ccnt;

   logic        tmr_clear;
   logic        tmr_en;
   logic        tmr_expired;

   assign tmr_clear = (state == S_EXECUTE);
   assign tmr_en    = (state == S_MEMORY) && !bus.mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      nxt      = state;
      stat_nxt = stat_q;
      unique case (state)
         S_IDLE: begin
            if (bus.start) nxt = S_FETCH;
         end
         S_FETCH: begin
            if (bus.imem_error) begin
               nxt      = S_HALT;
               stat_nxt = STAT_ADR;
            end else if (!bus.instr_valid) begin
               nxt      = S_HALT;
               stat_nxt = STAT_INS;
            end else if (bus.icode == I_HALT) begin
               nxt      = S_HALT;
               stat_nxt = STAT_HLT;
            end else begin
               nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            nxt = S_EXECUTE;
         end
         S_EXECUTE: begin
            nxt = is_mem_icode(icode_q) ? S_MEMORY : S_WRITEBACK;
         end
         S_MEMORY: begin
            // A data fault outranks a completion in the same cycle.
            if (bus.dmem_error) begin
               nxt      = S_HALT;
               stat_nxt = STAT_ADR;
            end else if (bus.mem_ready) begin
               nxt = S_WRITEBACK;
            end else if (tmr_expired) begin
               nxt      = S_HALT;
               stat_nxt = STAT_ADR;
            end
         end
         S_WRITEBACK: begin
            nxt = S_PCUPD;
         end
         S_PCUPD: begin
            nxt = bus.step_mode ? S_IDLE : S_FETCH;
         end
         S_HALT: begin
            nxt = S_HALT;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         stat_q    <= STAT_AOK;
         icode_q   <= '0;
         f_q       <= 1'b0;
         d_q       <= 1'b0;
         e_q       <= 1'b0;
         w_q       <= 1'b0;
         pc_q      <= 1'b0;
         mem_req_q <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         icnt      <= '0;
         ccnt      <= '0;
      end else begin
         state     <= nxt;
         stat_q    <= stat_nxt;
         if (state == S_FETCH) icode_q <= bus.icode;
         f_q       <= (nxt == S_FETCH);
         d_q       <= (nxt == S_DECODE);
         e_q       <= (nxt == S_EXECUTE);
         w_q       <= (nxt == S_WRITEBACK);
         pc_q      <= (nxt == S_PCUPD);
         mem_req_q <= (nxt == S_MEMORY);
         busy_q    <= !(nxt inside {S_IDLE, S_HALT});
         halted_q  <= (nxt == S_HALT);
         if (busy_q) ccnt <= ccnt + 64'd1;
         if (state == S_PCUPD) icnt <= icnt + 64'd1;
      end
   end

   assign bus.f_en        = f_q;
   assign bus.d_en        = d_q;
   assign bus.e_en        = e_q;
   assign bus.w_en        = w_q;
   assign bus.pc_en       = pc_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.m_en        = mem_req_q & bus.mem_ready & ~bus.dmem_error;
   assign bus.stat        = stat_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.instr_count = icnt;
   assign bus.cycle_count = ccnt;

endmodule

// File: tb/tb_y86_seq_sequencer.sv
// Randomized scoreboard bench for y86_seq_sequencer.
module tb_y86_seq_sequencer;

   localparam int unsigned TMO = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   y86_seq_sequencer_if bus ();

   y86_seq_sequencer #(
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              halts;
      logic [2:0]      stat;
      int              cyc;
      int              men;
      longint unsigned icnt;
      longint unsigned ccnt;
   } exp_t;

   exp_t            sb[$];
   int              n_cmp = 0;
   int              n_bad = 0;
   longint unsigned m_retired;
   longint unsigned m_busy;
   logic [2:0]      m_last_stat;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_mem(input int ic);
      return ic inside {4, 5, 8, 9, 10, 11};
   endfunction

   // Expected outcome of one instruction from its inputs alone.
   function automatic exp_t model(input int ic, input bit valid,
                                  input bit imem, input int n,
                                  input bit derr);
      exp_t e;
      e.halts = 1'b1;
      e.stat  = 3'd1;
      e.men   = 0;
      e.cyc   = 1;
      e.icnt  = 0;
      e.ccnt  = 0;
      if (imem) e.stat = 3'd3;
      else if (!valid) e.stat = 3'd4;
      else if (ic == 0) e.stat = 3'd2;
      else if (!is_mem(ic)) begin
         e.halts = 1'b0;
         e.cyc   = 5;
      end else if (n >= int'(TMO)) begin
         e.stat = 3'd3;
         e.cyc  = 3 + int'(TMO);
      end else if (derr) begin
         e.stat = 3'd3;
         e.cyc  = 4 + n;
      end else begin
         e.halts = 1'b0;
         e.cyc   = 6 + n;
         e.men   = 1;
      end
      return e;
   endfunction

   task automatic wait_sig(input bit mem, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((!mem && bus.f_en) || (mem && bus.mem_req)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_%s: got timeout expected strobe",
                  mem ? "mem_req" : "f_en");
      end
   endtask

   task automatic do_instr(input int ic, input bit valid, input bit imem,
                           input int n, input bit derr,
                           input bit drop_start, output bit halts);
      exp_t e;
      bit   ok;
      halts = 1'b1;
      wait_sig(1'b0, ok);
      if (!ok) return;
      bus.icode       = 4'(ic);
      bus.instr_valid = valid;
      bus.imem_error  = imem;
      if (drop_start) bus.start = 1'b0;
      e = model(ic, valid, imem, n, derr);
      e.icnt = m_retired;
      m_busy += longint'(e.cyc);
      e.ccnt = e.halts ? m_busy : m_busy - 1;
      if (!e.halts) m_retired++;
      else m_last_stat = e.stat;
      sb.push_back(e);
      halts = e.halts;
      @(negedge clk);
      bus.icode       = 4'($urandom);
      bus.instr_valid = 1'($urandom);
      bus.imem_error  = 1'b0;
      if (valid && !imem && is_mem(ic)) begin
         wait_sig(1'b1, ok);
         if (!ok) return;
         for (int j = 0; j < 40 && bus.mem_req; j++) begin
            bus.mem_ready  = (j == n);
            bus.dmem_error = derr && (j == n);
            @(negedge clk);
         end
         bus.dmem_error = 1'b0;
      end
      bus.mem_ready = 1'($urandom);
   endtask

   task automatic rand_instr(input bit faults, input bit drop_start,
                             output bit halts);
      int r;
      int ic;
      int n;
      r  = $urandom_range(0, 99);
      ic = (faults && r >= 8 && r < 11) ? 0 : $urandom_range(1, 11);
      n  = (faults && $urandom_range(0, 7) == 0)
           ? int'(TMO) + $urandom_range(0, 3)
           : $urandom_range(0, TMO - 1);
      do_instr(ic, !(faults && r >= 4 && r < 8), faults && r < 4, n,
               faults && $urandom_range(0, 9) == 0, drop_start, halts);
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.step_mode   = 1'b0;
      bus.icode       = 4'h0;
      bus.instr_valid = 1'b1;
      bus.imem_error  = 1'b0;
      bus.mem_ready   = 1'b0;
      bus.dmem_error  = 1'b0;
      repeat (2) @(negedge clk);
      sb.delete();
      m_retired = 0;
      m_busy    = 0;
      check("rst_strobes", {bus.f_en, bus.d_en, bus.e_en, bus.m_en,
                            bus.w_en, bus.pc_en, bus.mem_req}, 0);
      check("rst_stat", bus.stat, 1);
      check("rst_flags", {bus.busy, bus.halted}, 0);
      check("rst_icnt", bus.instr_count, 0);
      check("rst_ccnt", bus.cycle_count, 0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic sticky_halt();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.start = ~bus.start;
         #2;
         check("halt_sticky", {bus.halted, bus.busy, bus.f_en}, 3'b100);
         check("halt_stat", bus.stat, m_last_stat);
      end
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic free_run(input int len);
      bit h;
      h = 1'b0;
      bus.start = 1'b1;
      for (int i = 0; i < len && !h; i++) rand_instr(1'b1, 1'b0, h);
      if (!h) do_instr(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, h);
      sticky_halt();
   endtask

   // Monitor: measures each instruction from FETCH to retire or halt.
   exp_t ex;
   int   cyc;
   int   men;
   int   wen;
   bit   active;
   bit   prev_pc;

   initial begin
      active  = 1'b0;
      prev_pc = 1'b0;
      cyc = 0;
      men = 0;
      wen = 0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            active  = 1'b0;
            prev_pc = 1'b0;
         end else begin
            if (prev_pc) begin
               if (bus.step_mode) check("step_idle", bus.busy, 0);
               else check("refetch", bus.f_en, 1);
            end
            check("onehot", $countones({bus.f_en, bus.d_en, bus.e_en,
                  bus.w_en, bus.pc_en, bus.mem_req}) <= 1, 1);
            if (bus.f_en) begin
               active = 1'b1;
               cyc = 1;
               men = 0;
               wen = 0;
            end else if (active && bus.busy) begin
               cyc++;
            end
            if (bus.m_en) men++;
            if (bus.w_en) wen++;
            if (active && (bus.pc_en || bus.halted)) begin
               active = 1'b0;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL sb_empty: got retire expected none");
               end else begin
                  ex = sb.pop_front();
                  check("halted", bus.halted, ex.halts);
                  check("stat", bus.stat, ex.stat);
                  check("latency", cyc, ex.cyc);
                  check("m_en_cnt", men, ex.men);
                  check("w_en_cnt", wen, ex.halts ? 0 : 1);
                  check("instr_count", bus.instr_count, ex.icnt);
                  check("cycle_count", bus.cycle_count, ex.ccnt);
               end
            end
            prev_pc = bus.pc_en;
         end
      end
   end

   initial begin
      bit h;
      do_reset();
      // Straight OPq stream, then random traffic in free-run.
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) do_instr(6, 1'b1, 1'b0, 0, 1'b0, 1'b0, h);
      for (int i = 0; i < 20 && !h; i++) rand_instr(1'b1, 1'b0, h);
      if (!h) do_instr(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, h);
      sticky_halt();

      // Halt on third fetch, after a 2-wait mrmovq.
      do_reset();
      bus.start = 1'b1;
      do_instr(6, 1'b1, 1'b0, 0, 1'b0, 1'b0, h);
      do_instr(5, 1'b1, 1'b0, 2, 1'b0, 1'b0, h);
      do_instr(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, h);
      sticky_halt();

      // Directed faults.
      do_reset();
      bus.start = 1'b1;
      do_instr(6, 1'b0, 1'b0, 0, 1'b0, 1'b0, h);
      sticky_halt();
      do_reset();
      bus.start = 1'b1;
      do_instr(5, 1'b1, 1'b0, 0, 1'b1, 1'b0, h);
      sticky_halt();
      do_reset();
      bus.start = 1'b1;
      do_instr(9, 1'b1, 1'b0, TMO + 5, 1'b0, 1'b0, h);
      sticky_halt();
      do_reset();
      bus.start = 1'b1;
      do_instr(0, 1'b1, 1'b1, 0, 1'b0, 1'b0, h);
      sticky_halt();

      // Step mode: one pulse, then start held high.
      do_reset();
      bus.step_mode = 1'b1;
      bus.start = 1'b1;
      do_instr(4, 1'b1, 1'b0, 1, 1'b0, 1'b1, h);
      repeat (8) @(negedge clk);
      #2;
      check("step_busy", bus.busy, 0);
      check("step_icnt", bus.instr_count, 1);
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) rand_instr(1'b0, 1'b0, h);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      check("step_busy2", bus.busy, 0);
      check("step_icnt2", bus.instr_count, m_retired);
      check("step_ccnt", bus.cycle_count, m_busy);

      // Several randomized free-run programs.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         free_run(25);
      end

      // Asynchronous reset in the middle of a memory access.
      do_reset();
      bus.start = 1'b1;
      wait_sig(1'b0, h);
      bus.icode = 4'h5;
      wait_sig(1'b1, h);
      check("pre_rst_req", bus.mem_req, 1);
      #3;
      reset = 1'b1;
      #1;
      check("arst_req", {bus.mem_req, bus.busy, bus.m_en}, 0);
      check("arst_icnt", bus.instr_count, 0);
      check("arst_ccnt", bus.cycle_count, 0);
      check("arst_stat", bus.stat, 1);
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
